rv32_decode_stage: RTL and testbench

RV32_DECODE_STAGE -- requirements
Module: rv32_decode_stage

---
 rtl/rv32_decode_stage.sv | 164 ++++++++++++++++
 tb/tb_rv32_decode_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_decode_stage.sv
// rv32_decode_stage: registered RV32I field decoder with a valid/ready handshake on both sides.
// Define RV32_DECODE_SKID_EN for a main+skid buffer that removes the out_ready -> in_ready path.

package rv32_decode_pkg;

    typedef logic [31:0] rv32_inst_t;

    typedef struct packed {
        rv32_inst_t  inst;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [11:0] funct12;
        logic [31:0] imm;
        logic        decode_error;
    } rv32_fields_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    function automatic rv32_fields_t rv32_decode(input rv32_inst_t inst);
        rv32_fields_t f;
        logic         known;
        f         = '0;
        known     = 1'b1;
        f.inst    = inst;
        f.opcode  = inst[6:0];
        f.rd      = inst[11:7];
        f.funct3  = inst[14:12];
        f.rs1     = inst[19:15];
        f.rs2     = inst[24:20];
        f.funct7  = inst[31:25];
        f.funct12 = inst[31:20];
        case (inst[6:0])
            OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM:
                f.imm = {{20{inst[31]}}, inst[31:20]};
            OPC_STORE:
                f.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH:
                f.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                f.imm = {inst[31:12], 12'b0};
            OPC_JAL:
                f.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            OPC_OP:
                f.imm = '0;
            default:
                known = 1'b0;
        endcase
        f.decode_error = (inst[1:0] != 2'b11) || !known
            || ((inst[6:0] == OPC_BRANCH) && (inst[14:13] == 2'b01))
            || ((inst[6:0] == OPC_OP) && (inst[31:25] != 7'b0000000) && (inst[31:25] != 7'b0100000))
            || ((inst[6:0] == OPC_OP) && (inst[31:25] == 7'b0100000)
                && (inst[14:12] != 3'b000) && (inst[14:12] != 3'b101));
        return f;
    endfunction

endpackage

module rv32_decode_stage
    import rv32_decode_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  rv32_inst_t   in_inst,
    input  logic [31:0]  in_pc,
    output logic         out_valid,
    input  logic         out_ready,
    output rv32_fields_t out_fields,
    output logic [31:0]  out_pc
);

    rv32_fields_t w_dec;
    logic         w_in_fire;
    logic         w_out_fire;

    logic         r_main_valid;
    rv32_fields_t r_main_fields;
    logic [31:0]  r_main_pc;

    assign w_dec      = rv32_decode(in_inst);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_main_valid && out_ready;

    assign out_valid  = r_main_valid;
    assign out_fields = r_main_fields;
    assign out_pc     = r_main_pc;

`ifdef RV32_DECODE_SKID_EN
    logic         r_skid_valid;
    rv32_fields_t r_skid_fields;
    logic [31:0]  r_skid_pc;

    // rst gates in_ready directly so it is low the instant reset asserts.
    assign in_ready = !rst && !flush && !r_skid_valid;

    // NOTE: payload registers are reset too, because out_fields/out_pc must read zero during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid  <= 1'b0;
            r_main_fields <= '0;
            r_main_pc     <= '0;
            r_skid_valid  <= 1'b0;
            r_skid_fields <= '0;
            r_skid_pc     <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || w_out_fire) begin
            if (r_skid_valid) begin
                r_main_valid  <= 1'b1;
                r_main_fields <= r_skid_fields;
                r_main_pc     <= r_skid_pc;
                r_skid_valid  <= 1'b0;
            end else begin
                r_main_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_main_fields <= w_dec;
                    r_main_pc     <= in_pc;
                end
            end
        end else if (w_in_fire) begin
            // Main is stalled: park the new word until main drains.
            r_skid_valid  <= 1'b1;
            r_skid_fields <= w_dec;
            r_skid_pc     <= in_pc;
        end
    end
`else
    assign in_ready = !rst && !flush && (!r_main_valid || out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid  <= 1'b0;
            r_main_fields <= '0;
            r_main_pc     <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_main_valid  <= 1'b1;
            r_main_fields <= w_dec;
            r_main_pc     <= in_pc;
        end else if (w_out_fire) begin
            r_main_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Scoreboard bench for rv32_decode_stage: driver pushes expected words on acceptance,
// a negedge monitor compares every presented output against the queue head.

module tb_rv32_decode_stage;
    import rv32_decode_pkg::*;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] imm;
        logic        err;
    } vec_t;

    typedef struct packed {
        rv32_fields_t fields;
        logic [31:0]  pc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    rv32_inst_t   in_inst;
    logic [31:0]  in_pc;
    logic         out_valid;
    logic         out_ready;
    rv32_fields_t out_fields;
    logic [31:0]  out_pc;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    vec_t vecs [19];

`ifdef RV32_DECODE_SKID_EN
    logic [2:0] bp_rdy = 3'b011;
`else
    logic [2:0] bp_rdy = 3'b001;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    rv32_decode_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_fields (out_fields),
        .out_pc     (out_pc)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic rv32_fields_t mk(input vec_t v);
        rv32_fields_t f;
        f.inst         = v.inst;
        f.opcode       = v.inst[6:0];
        f.rd           = v.inst[11:7];
        f.funct3       = v.inst[14:12];
        f.rs1          = v.inst[19:15];
        f.rs2          = v.inst[24:20];
        f.funct7       = v.inst[31:25];
        f.funct12      = v.inst[31:20];
        f.imm          = v.imm;
        f.decode_error = v.err;
        return f;
    endfunction

    task automatic expect_word(input vec_t v, input logic [31:0] pc);
        exp_t e;
        e.fields = mk(v);
        e.pc     = pc;
        sb.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input vec_t v, input logic [31:0] pc);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_inst  = v.inst;
        in_pc    = pc;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready) expect_word(v, pc);
        else check("send_timeout", 160'(in_ready), 160'(1'b1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 160'(sb.size()), 160'(0));
    endtask

    // Monitor: compare the head while presented (also proves stability under stall), pop on transfer.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 160'(out_valid), 160'(1'b0));
            end else begin
                check("out_fields", 160'(out_fields), 160'(sb[0].fields));
                check("out_pc", 160'(out_pc), 160'(sb[0].pc));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int start;
        int k;
        // inst, imm, decode_error
        vecs = '{
            '{32'h00500093, 32'h00000005, 1'b0},  // addi x1,x0,5
            '{32'hFE000EE3, 32'hFFFFFFFC, 1'b0},  // beq x0,x0,-4 (imm[11] = inst[7] = 1)
            '{32'h12345037, 32'h12345000, 1'b0},  // lui
            '{32'hFFFFFFFF, 32'h00000000, 1'b1},  // unknown opcode
            '{32'hFE112E23, 32'hFFFFFFFC, 1'b0},  // sw x1,-4(x2)
            '{32'h0010006F, 32'h00000800, 1'b0},  // jal x0,2048
            '{32'hFFDFF06F, 32'hFFFFFFFC, 1'b0},  // jal x0,-4
            '{32'hFFFFF197, 32'hFFFFF000, 1'b0},  // auipc x3,0xfffff
            '{32'h402081B3, 32'h00000000, 1'b0},  // sub
            '{32'h402091B3, 32'h00000000, 1'b1},  // funct7 0100000 with funct3 001
            '{32'h022081B3, 32'h00000000, 1'b1},  // funct7 0000001 on OP
            '{32'hFE002EE3, 32'hFFFFFFFC, 1'b1},  // branch funct3 010
            '{32'hFFF02083, 32'hFFFFFFFF, 1'b0},  // lw x1,-1(x0)
            '{32'h0FF0000F, 32'h000000FF, 1'b0},  // fence
            '{32'h00000073, 32'h00000000, 1'b0},  // ecall
            '{32'h00500090, 32'h00000000, 1'b1},  // inst[1:0] = 00
            '{32'hFE003EE3, 32'hFFFFFFFC, 1'b1},  // branch funct3 011
            '{32'hFFF080E7, 32'hFFFFFFFF, 1'b0},  // jalr x1,-1(x1)
            '{32'h4020D1B3, 32'h00000000, 1'b0}   // sra
        };

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 160'(out_valid), 160'(1'b0));
        check("rst_in_ready", 160'(in_ready), 160'(1'b0));
        check("rst_out_fields", 160'(out_fields), 160'(0));
        check("rst_out_pc", 160'(out_pc), 160'(0));
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 160'(in_ready), 160'(1'b1));
        @(posedge clk);
        #1;

        // Single word into an empty stage: presented exactly one cycle later.
        send(vecs[0], 32'h1000);
        check("addi_latency", 160'(out_valid), 160'(1'b1));

        // Back-to-back stream with out_ready high: one word per cycle, in order.
        start = cyc;
        for (int i = 1; i < 19; i++) send(vecs[i], 32'h1000 + 32'(4 * i));
        check("stream_cycles", 160'(cyc - start), 160'(18));
        wait_drain("stream_drain");

        // Backpressure: out_ready low for 3 cycles while words are offered.
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_inst  = vecs[4 + k].inst;
            in_pc    = 32'h2000 + 32'(4 * k);
            @(negedge clk);
            check("bp_in_ready", 160'(in_ready), 160'(bp_rdy[c]));
            check("bp_out_valid", 160'(out_valid), 160'(c != 0));
            if (in_ready) begin
                expect_word(vecs[4 + k], 32'h2000 + 32'(4 * k));
                k++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (k < 3) begin
            send(vecs[4 + k], 32'h2000 + 32'(4 * k));
            k++;
        end
        wait_drain("bp_drain");

        // Flush while full: held words vanish, offered word is refused.
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            in_inst  = vecs[8 + c].inst;
            in_pc    = 32'h3000 + 32'(4 * c);
            @(negedge clk);
            if (in_ready) expect_word(vecs[8 + c], 32'h3000 + 32'(4 * c));
            @(posedge clk);
            #1;
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_inst  = vecs[10].inst;
        in_pc    = 32'h3100;
        @(negedge clk);
        check("flush_in_ready", 160'(in_ready), 160'(1'b0));
        @(posedge clk);
        #1;
        sb.delete();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 160'(out_valid), 160'(1'b0));
        out_ready = 1'b1;
        send(vecs[12], 32'h3200);
        wait_drain("flush_next_word");

        // Flush coinciding with an output transfer: that transfer still completes.
        out_ready = 1'b0;
        send(vecs[13], 32'h4000);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_xfer_done", 160'(sb.size()), 160'(0));
        check("flush_xfer_valid", 160'(out_valid), 160'(1'b0));

        // Reset mid-stream: outputs clear at once, stage ready after release.
        out_ready = 1'b0;
        send(vecs[14], 32'h5000);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 160'(out_valid), 160'(1'b0));
        check("midrst_in_ready", 160'(in_ready), 160'(1'b0));
        check("midrst_out_fields", 160'(out_fields), 160'(0));
        check("midrst_out_pc", 160'(out_pc), 160'(0));
        sb.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", 160'(in_ready), 160'(1'b1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(vecs[16], 32'h6000);
        wait_drain("final_drain");
        repeat (3) @(posedge clk);
        #1;
        check("final_idle", 160'(out_valid), 160'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
